// File: rtl/aes_if_pkg.sv
// Shared definitions for the AES word-stream interface.
// Holds the block geometry and the state encoding used by the
// stream interface controller and its word shift registers.
package aes_if_pkg;

    localparam int WORD_W        = 32;
    localparam int BLK_W         = 128;
    localparam int WORDS_PER_BLK = 4;

    typedef enum logic [1:0] {
        S_FILL  = 2'd0,
        S_START = 2'd1,
        S_WAIT  = 2'd2,
        S_DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/aes_blk_shift.sv
// 128-bit block register that moves one 32-bit word at a time.
// Used both to pack incoming words into a block and to serialize
// a captured block back out as words.
//
// Ports:
//   clk       clock
//   rst_n     asynchronous active-low reset, clears the block
//   load      parallel load of load_data (wins over shift)
//   load_data block value for a parallel load
//   shift     shift the block up by one word, shift_in enters at [31:0]
//   shift_in  word entering the low end on a shift
//   data      current block contents; [127:96] is the oldest word
module aes_blk_shift
    import aes_if_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load,
    input  logic [BLK_W-1:0]  load_data,
    input  logic              shift,
    input  logic [WORD_W-1:0] shift_in,
    output logic [BLK_W-1:0]  data
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data <= '0;
        end else if (load) begin
            data <= load_data;
        end else if (shift) begin
            data <= {data[BLK_W-WORD_W-1:0], shift_in};
        end
    end

endmodule

// File: rtl/aes_stream_if.sv
// Word-stream front/back end for the AES core.
// Packs four 32-bit input words into a 128-bit plaintext block,
// holds a latched key, starts the core for one cycle, captures the
// ciphertext on the core's done pulse and streams it back out as
// four 32-bit words. One block is in flight at a time.
//
// Ports:
//   iClk, iRsn          clock, asynchronous active-low reset
//   iKeyWr, iKey        key load strobe and value (only taken between blocks)
//   iInData/iInValid/oInReady     plaintext word stream
//   oOutData/oOutValid/iOutReady  ciphertext word stream
//   oStAes              one-cycle start pulse to the core
//   oAesKey, oPlainText key and packed block presented to the core
//   iAesDone, iCpText   core done pulse and ciphertext
//   oBusy               high whenever a block is not being filled
//   oErr, iErrClr       sticky error flag and its clear
module aes_stream_if
    import aes_if_pkg::*;
#(
    parameter int DONE_TIMEOUT = 64,
    parameter int TMR_W        = 8
) (
    input  logic              iClk,
    input  logic              iRsn,
    input  logic              iKeyWr,
    input  logic [BLK_W-1:0]  iKey,
    input  logic [WORD_W-1:0] iInData,
    input  logic              iInValid,
    output logic              oInReady,
    output logic [WORD_W-1:0] oOutData,
    output logic              oOutValid,
    input  logic              iOutReady,
    output logic              oStAes,
    output logic [BLK_W-1:0]  oAesKey,
    output logic [BLK_W-1:0]  oPlainText,
    input  logic              iAesDone,
    input  logic [BLK_W-1:0]  iCpText,
    output logic              oBusy,
    output logic              oErr,
    input  logic              iErrClr
);

    // The abandon decision is registered into oErr one cycle later and the
    // counter starts at zero the cycle after the start pulse, so deciding at
    // DONE_TIMEOUT-2 makes oErr rise exactly DONE_TIMEOUT cycles after oStAes.
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(DONE_TIMEOUT - 2);

    state_t            state, state_next;
    logic [1:0]        cnt, cnt_next;
    logic [TMR_W-1:0]  tmr, tmr_next;
    logic [BLK_W-1:0]  key_q;
    logic              err_q;
    logic [BLK_W-1:0]  out_buf;

    logic              in_shift;
    logic              in_clear;
    logic              out_load;
    logic              out_shift;
    logic              key_load;
    logic              err_set;

    // Input packer: each accepted word enters at the bottom, so after four
    // words the first one sits in [127:96]. Cleared when a block is abandoned.
    aes_blk_shift u_packer (
        .clk       (iClk),
        .rst_n     (iRsn),
        .load      (in_clear),
        .load_data ('0),
        .shift     (in_shift),
        .shift_in  (iInData),
        .data      (oPlainText)
    );

    // Output serializer: the top word is always the one on offer; a consumed
    // word is shifted out so the next one moves up.
    aes_blk_shift u_serializer (
        .clk       (iClk),
        .rst_n     (iRsn),
        .load      (out_load),
        .load_data (iCpText),
        .shift     (out_shift),
        .shift_in  ('0),
        .data      (out_buf)
    );

    assign oOutData = out_buf[BLK_W-1 -: WORD_W];
    assign oAesKey  = key_q;
    assign oErr     = err_q;

    // Next-state and handshake decode. A key write is only legal while the
    // packer is empty; anywhere else it is dropped and flagged. A done pulse
    // outside S_WAIT is simply not looked at.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        tmr_next   = tmr;
        in_shift   = 1'b0;
        in_clear   = 1'b0;
        out_load   = 1'b0;
        out_shift  = 1'b0;
        key_load   = 1'b0;
        err_set    = 1'b0;
        oInReady   = 1'b0;
        oStAes     = 1'b0;
        oOutValid  = 1'b0;
        oBusy      = 1'b1;

        if (iKeyWr) begin
            if (state == S_FILL && cnt == 2'd0) begin
                key_load = 1'b1;
            end else begin
                err_set = 1'b1;
            end
        end

        case (state)
            S_FILL: begin
                oInReady = 1'b1;
                oBusy    = 1'b0;
                if (iInValid) begin
                    in_shift = 1'b1;
                    if (cnt == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = S_START;
                    end else begin
                        cnt_next = cnt + 2'd1;
                    end
                end
            end
            S_START: begin
                oStAes     = 1'b1;
                tmr_next   = '0;
                state_next = S_WAIT;
            end
            S_WAIT: begin
                if (iAesDone) begin
                    out_load   = 1'b1;
                    state_next = S_DRAIN;
                end else if (tmr == TMR_LAST) begin
                    err_set    = 1'b1;
                    in_clear   = 1'b1;
                    cnt_next   = 2'd0;
                    state_next = S_FILL;
                end else begin
                    tmr_next = tmr + TMR_W'(1);
                end
            end
            S_DRAIN: begin
                oOutValid = 1'b1;
                if (iOutReady) begin
                    out_shift = 1'b1;
                    if (cnt == 2'd3) begin
                        cnt_next   = 2'd0;
                        state_next = S_FILL;
                    end else begin
                        cnt_next = cnt + 2'd1;
                    end
                end
            end
            default: begin
                state_next = S_FILL;
                cnt_next   = 2'd0;
            end
        endcase
    end

    // State, counters, key and error flag. An error set in the same cycle as
    // a clear request leaves the flag set.
    always_ff @(posedge iClk or negedge iRsn) begin
        if (!iRsn) begin
            state <= S_FILL;
            cnt   <= 2'd0;
            tmr   <= '0;
            key_q <= '0;
            err_q <= 1'b0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
            tmr   <= tmr_next;
            if (key_load) begin
                key_q <= iKey;
            end
            if (err_set) begin
                err_q <= 1'b1;
            end else if (iErrClr) begin
                err_q <= 1'b0;
            end
        end
    end

endmodule

// File: doc/aes_stream_if.md
Name: aes_stream_if

Overview:
- Word-stream front/back end for the AES core.
- Packs four 32-bit input words into one 128-bit plaintext block and holds a latched 128-bit key.
- Issues a one-cycle start to the core, captures the ciphertext on the core's done pulse, and serializes it as four 32-bit output words.
- Sits between the system bus/DMA and the AES core. Handles one block at a time; blocks do not overlap.

Parameters:
DONE_TIMEOUT, 64, max cycles from oStAes to iAesDone before the block is abandoned (range 2..255)
TMR_W, 8, width of the watchdog counter; must hold DONE_TIMEOUT

Ports:
iClk  in  1  clock
iRsn  in  1  reset, asynchronous, active-low
iKeyWr  in  1  key load strobe
iKey  in  128  key value, sampled when iKeyWr is accepted
iInData  in  32  plaintext word
iInValid  in  1  input word valid
oInReady  out  1  input word accepted when iInValid & oInReady
oOutData  out  32  ciphertext word
oOutValid  out  1  output word valid
iOutReady  in  1  output word consumed when oOutValid & iOutReady
oStAes  out  1  one-cycle start pulse to the AES core
oAesKey  out  128  latched key to the core
oPlainText  out  128  packed block to the core
iAesDone  in  1  core done pulse; iCpText valid in that cycle
iCpText  in  128  core ciphertext
oBusy  out  1  high in every state except S_FILL
oErr  out  1  sticky error flag
iErrClr  in  1  clears oErr

Behaviour:
- Clock and reset: single clock iClk. Reset iRsn is asynchronous, active-low.
- Reset values:
  - state = S_FILL, word count = 0.
  - oAesKey, oPlainText, oOutData, the output buffer, oStAes, oOutValid, oBusy and oErr are all 0.
  - oInReady = 1, since it is high in S_FILL.
  - Reset mid-block discards all partial data; the core is not notified.
- Word order (FIPS-197 byte order):
  - First input word goes to bits [127:96], fourth to [31:0].
  - Output is emitted in the same order: [127:96] first.
- FSM:
  - S_FILL:
    - oInReady = 1; each handshake stores one word and increments cnt (0..3).
    - The handshake at cnt = 3 moves to S_START and resets cnt to 0.
  - S_START: oStAes = 1 for exactly one cycle; clears the watchdog; goes to S_WAIT.
  - S_WAIT:
    - If iAesDone: register iCpText into the output buffer and go to S_DRAIN.
    - Else, when the watchdog reaches DONE_TIMEOUT: set oErr, discard the block, go to S_FILL.
  - S_DRAIN:
    - oOutValid = 1 and oOutData = the current buffer word.
    - Each handshake advances cnt; the handshake at cnt = 3 returns to S_FILL with cnt = 0.
    - If iOutReady is low, oOutData holds stable.
- Latency:
  - 4th input handshake at cycle T → oStAes high at T+1.
  - iAesDone at cycle D → oOutValid high at D+1 with word 0.
- Key handling:
  - iKeyWr is accepted only in S_FILL with cnt = 0; oAesKey updates the next cycle.
  - iKeyWr in any other state or count is ignored and sets oErr.
  - If iKeyWr and an input handshake occur in the same cycle at cnt = 0, both are accepted.
- oPlainText and oAesKey hold stable from S_START until the block returns to S_FILL.
- iAesDone outside S_WAIT (including the S_START cycle) is ignored; no state change, no error.
- oErr: iErrClr clears it; a set event in the same cycle wins over the clear.
- oOutValid never drops without a handshake, except on reset.

Decomposition:
- Shared package aes_if_pkg holds:
  - state encoding localparams S_FILL=2'd0, S_START=2'd1, S_WAIT=2'd2, S_DRAIN=2'd3;
  - WORD_W = 32, BLK_W = 128, WORDS_PER_BLK = 4.
- One sub-module is natural: aes_blk_shift, a 128-bit word shift register with load-parallel and shift-word controls.
  - Instantiated twice: as the input packer and as the output serializer.

Test Plan:
- FIPS-197 C.1 vector with the real AesCore:
  - Stimulus: key 000102030405060708090a0b0c0d0e0f; words 00112233, 44556677, 8899aabb, ccddeeff.
  - Required output, in order: 69c4e0d8, 6a7b0430, d8cdb780, 70b4c55a.
  - oStAes is seen exactly once.
- Output backpressure: iOutReady low for 5 cycles at word 2 → oOutData holds d8cdb780 and oOutValid stays 1; sequence completes in order.
- Watchdog: core model never asserts done → oErr = 1 exactly DONE_TIMEOUT (64) cycles after oStAes; FSM returns to S_FILL; no output words.
- Illegal key write: iKeyWr during S_WAIT with key FF..FF → oAesKey unchanged and oErr = 1; iErrClr pulse → oErr = 0.
- Reset mid-drain: assert iRsn = 0 after output word 1 → oOutValid = 0, oBusy = 0 and oInReady = 1 immediately; the next block encrypts correctly.
- Spurious done: pulse iAesDone while in S_FILL with cnt = 2 → no state change, no output, oErr stays 0.
